// File: rtl/mat_sched_pkg.sv
// Shared types and constants for the matrix-op command scheduler.
package mat_sched_pkg;

   localparam logic [2:0]  MODE_AS       = 3'd1;
   localparam logic [2:0]  MODE_SA       = 3'd2;
   localparam logic [3:0]  CTRL_IDLE     = 4'd0;
   localparam int unsigned START_TIMEOUT = 8;

   // Widest tag the queue payload can carry; the top narrows it to TAG_W.
   localparam int unsigned TAG_W_MAX = 16;

   typedef struct packed {
      logic [2:0]           mode;
      logic [31:0]          left;
      logic [31:0]          right;
      logic [31:0]          addsrc;
      logic [31:0]          save;
      logic [10:0]          size;
      logic [TAG_W_MAX-1:0] tag;
   } mat_cmd_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_START,
      S_RUN,
      S_DONE
   } sched_state_e;

   function automatic logic cmd_legal(input mat_cmd_t cmd);
      return ((cmd.mode == MODE_AS) || (cmd.mode == MODE_SA)) && (cmd.size != 11'd0);
   endfunction

endpackage

// File: rtl/mat_cmd_fifo.sv
// Command queue: DEPTH-entry FIFO with an extra pointer bit for full/empty,
// show-ahead read, push accepted when full only alongside a pop.
module mat_cmd_fifo
   import mat_sched_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter type         payload_t = mat_cmd_t
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  logic     pop,
   output logic     full,
   output logic     empty,
   input  payload_t din,
   output payload_t dout
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        wr_en;
   logic        rd_en;
   payload_t    mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: empty pointers mask stale contents.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mat_op_scheduler.sv
// Matrix-op command sequencer in front of mem_ctrl: queues, launches, tracks completion.
// Optional perf counters enabled by defining MAT_SCHED_PERF_EN.
module mat_op_scheduler
   import mat_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_mode,
   input  logic [31:0]      cmd_left,
   input  logic [31:0]      cmd_right,
   input  logic [31:0]      cmd_addsrc,
   input  logic [31:0]      cmd_save,
   input  logic [10:0]      cmd_size,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic             calc_init,
   output logic [2:0]       mem_mode,
   output logic [31:0]      base_left,
   output logic [31:0]      base_right,
   output logic [31:0]      base_addsrc,
   output logic [31:0]      base_save,
   output logic [10:0]      matrix_size,
   input  logic [3:0]       ctrl_state,
   output logic             done_valid,
   output logic [TAG_W-1:0] done_tag,
   output logic             done_err,
   output logic             busy
`ifdef MAT_SCHED_PERF_EN
   ,
   output logic [31:0]      perf_busy_cycles,
   output logic [15:0]      perf_ops
`endif
);

   mat_cmd_t     cmd_in;
   mat_cmd_t     head;
   mat_cmd_t     op_q;
   sched_state_e state_q;
   logic [3:0]   timer_q;
   logic         ready_q;
   logic         calc_init_q;
   logic         done_valid_q;
   logic         done_err_q;
   logic         push;
   logic         pop;
   logic         full;
   logic         empty;
   logic         unused_tag;

   always_comb begin
      cmd_in        = '0;
      cmd_in.mode   = cmd_mode;
      cmd_in.left   = cmd_left;
      cmd_in.right  = cmd_right;
      cmd_in.addsrc = cmd_addsrc;
      cmd_in.save   = cmd_save;
      cmd_in.size   = cmd_size;
      cmd_in.tag    = TAG_W_MAX'(cmd_tag);
   end

   // ready_q keeps cmd_ready low while in reset and rises on the first clock after.
   assign cmd_ready = ready_q && !full;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == S_IDLE) && !empty;

   mat_cmd_fifo #(
      .DEPTH     (DEPTH),
      .payload_t (mat_cmd_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .din   (cmd_in),
      .dout  (head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         timer_q      <= '0;
         ready_q      <= 1'b0;
         calc_init_q  <= 1'b0;
         done_valid_q <= 1'b0;
         done_err_q   <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         unique case (state_q)
            S_IDLE: begin
               if (!empty) begin
                  op_q <= head;
                  if (cmd_legal(head)) begin
                     state_q     <= S_LAUNCH;
                     calc_init_q <= 1'b1;
                  end else begin
                     state_q      <= S_DONE;
                     done_valid_q <= 1'b1;
                     done_err_q   <= 1'b1;
                  end
               end
            end
            S_LAUNCH: begin
               calc_init_q <= 1'b0;
               timer_q     <= '0;
               state_q     <= S_WAIT_START;
            end
            S_WAIT_START: begin
               if (ctrl_state != CTRL_IDLE) begin
                  state_q <= S_RUN;
               end else if (timer_q == 4'(START_TIMEOUT - 1)) begin
                  state_q      <= S_DONE;
                  done_valid_q <= 1'b1;
                  done_err_q   <= 1'b1;
               end else begin
                  timer_q <= timer_q + 4'd1;
               end
            end
            S_RUN: begin
               if (ctrl_state == CTRL_IDLE) begin
                  state_q      <= S_DONE;
                  done_valid_q <= 1'b1;
                  done_err_q   <= 1'b0;
               end
            end
            S_DONE: begin
               done_valid_q <= 1'b0;
               done_err_q   <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Config is driven straight from the op registers, so it only moves on a pop.
   assign calc_init   = calc_init_q;
   assign mem_mode    = op_q.mode;
   assign base_left   = op_q.left;
   assign base_right  = op_q.right;
   assign base_addsrc = op_q.addsrc;
   assign base_save   = op_q.save;
   assign matrix_size = op_q.size;
   assign done_valid  = done_valid_q;
   assign done_err    = done_err_q;
   assign done_tag    = op_q.tag[TAG_W-1:0];
   assign busy        = !empty || (state_q != S_IDLE);
   assign unused_tag  = ^op_q.tag;

`ifdef MAT_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_busy_cycles <= '0;
         perf_ops         <= '0;
      end else begin
         if ((state_q == S_RUN) && (perf_busy_cycles != '1)) begin
            perf_busy_cycles <= perf_busy_cycles + 32'd1;
         end
         if (done_valid_q && !done_err_q && (perf_ops != '1)) begin
            perf_ops <= perf_ops + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mat_op_scheduler.sv
// Directed self-checking bench for mat_op_scheduler with a behavioural mem_ctrl model.
module tb_mat_op_scheduler;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_mode;
   logic [31:0]      cmd_left;
   logic [31:0]      cmd_right;
   logic [31:0]      cmd_addsrc;
   logic [31:0]      cmd_save;
   logic [10:0]      cmd_size;
   logic [TAG_W-1:0] cmd_tag;
   logic             calc_init;
   logic [2:0]       mem_mode;
   logic [31:0]      base_left;
   logic [31:0]      base_right;
   logic [31:0]      base_addsrc;
   logic [31:0]      base_save;
   logic [10:0]      matrix_size;
   logic [3:0]       ctrl_state;
   logic             done_valid;
   logic [TAG_W-1:0] done_tag;
   logic             done_err;
   logic             busy;
`ifdef MAT_SCHED_PERF_EN
   logic [31:0]      perf_busy_cycles;
   logic [15:0]      perf_ops;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mat_op_scheduler #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_mode    (cmd_mode),
      .cmd_left    (cmd_left),
      .cmd_right   (cmd_right),
      .cmd_addsrc  (cmd_addsrc),
      .cmd_save    (cmd_save),
      .cmd_size    (cmd_size),
      .cmd_tag     (cmd_tag),
      .calc_init   (calc_init),
      .mem_mode    (mem_mode),
      .base_left   (base_left),
      .base_right  (base_right),
      .base_addsrc (base_addsrc),
      .base_save   (base_save),
      .matrix_size (matrix_size),
      .ctrl_state  (ctrl_state),
      .done_valid  (done_valid),
      .done_tag    (done_tag),
      .done_err    (done_err),
      .busy        (busy)
`ifdef MAT_SCHED_PERF_EN
      ,
      .perf_busy_cycles (perf_busy_cycles),
      .perf_ops         (perf_ops)
`endif
   );

   // mem_ctrl model: leaves IDLE the cycle after calc_init, stays busy run_len cycles.
   bit model_en = 1'b1;
   int run_len = 40;
   int mc_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_state <= 4'd0;
         mc_cnt     <= 0;
      end else if (model_en && calc_init) begin
         ctrl_state <= 4'd1;
         mc_cnt     <= run_len;
      end else if (mc_cnt > 1) begin
         mc_cnt <= mc_cnt - 1;
      end else if (mc_cnt == 1) begin
         mc_cnt     <= 0;
         ctrl_state <= 4'd0;
      end
   end

   int          calc_cnt = 0;
   int          calc_cyc = 0;
   int          zero_cyc = 0;
   logic [2:0]  launch_mode;
   logic [10:0] launch_size;
   logic [31:0] launch_left;
   logic [3:0]  prev_cs = 4'd0;
   int          done_tags[$];
   bit          done_errs[$];
   int          done_cycs[$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (calc_init) begin
            calc_cnt++;
            calc_cyc    = cyc;
            launch_mode = mem_mode;
            launch_size = matrix_size;
            launch_left = base_left;
         end
         if (done_valid) begin
            done_tags.push_back(int'(done_tag));
            done_errs.push_back(done_err);
            done_cycs.push_back(cyc);
         end
         if (ctrl_state == 4'd0 && prev_cs != 4'd0) zero_cyc = cyc;
      end
      prev_cs = ctrl_state;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Call at a falling edge; returns at the falling edge after acceptance.
   task automatic push_cmd(input logic [2:0] mode, input logic [10:0] size,
                           input logic [3:0] tag);
      int budget = 300;
      cmd_mode   = mode;
      cmd_size   = size;
      cmd_tag    = tag;
      cmd_left   = 32'h1000_0000 | 32'(tag);
      cmd_right  = 32'h2000_0000 | 32'(tag);
      cmd_addsrc = 32'h3000_0000 | 32'(tag);
      cmd_save   = 32'h4000_0000 | 32'(tag);
      cmd_valid  = 1'b1;
      while (!cmd_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) check_eq("push_ready", 64'(cmd_ready), 64'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_dones(input int n, input int budget);
      while (done_tags.size() < n && budget > 0) begin
         @(negedge clk);
         #1;
         budget--;
      end
      if (done_tags.size() < n) check_eq("done_wait", 64'(done_tags.size()), 64'(n));
   endtask

   task automatic clear_log();
      done_tags.delete();
      done_errs.delete();
      done_cycs.delete();
   endtask

   int c0;

   initial begin
      cmd_valid = 1'b0; cmd_mode = '0; cmd_size = '0; cmd_tag = '0;
      cmd_left = '0; cmd_right = '0; cmd_addsrc = '0; cmd_save = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_calc_init", 64'(calc_init), 64'd0);
      check_eq("rst_done_valid", 64'(done_valid), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check_eq("rst_mem_mode", 64'(mem_mode), 64'd0);
      check_eq("rst_matrix_size", 64'(matrix_size), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_ready", 64'(cmd_ready), 64'd1);

      // 1. Single AS op
      clear_log();
      push_cmd(3'd1, 11'd8, 4'd3);
      wait_dones(1, 300);
      check_eq("t1_calc_cnt", 64'(calc_cnt), 64'd1);
      check_eq("t1_mode", 64'(launch_mode), 64'd1);
      check_eq("t1_size", 64'(launch_size), 64'd8);
      check_eq("t1_left", 64'(launch_left), 64'h1000_0003);
      if (done_tags.size() >= 1) begin
         check_eq("t1_tag", 64'(done_tags[0]), 64'd3);
         check_eq("t1_err", 64'(done_errs[0]), 64'd0);
         check_eq("t1_done_lat", 64'(done_cycs[0] - zero_cyc), 64'd1);
         check_eq("t1_launch_to_done", 64'(done_cycs[0] - calc_cyc), 64'd42);
      end
      @(negedge clk);
      check_eq("t1_busy_idle", 64'(busy), 64'd0);
      check_eq("t1_mode_held", 64'(mem_mode), 64'd1);
      check_eq("t1_size_held", 64'(matrix_size), 64'd8);

      // 2. Queue full, in-order completion
      clear_log();
      c0 = calc_cnt;
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("t2_ready_%0d", i), 64'(cmd_ready), 64'd1);
         push_cmd(3'd1, 11'(16 + i), 4'(i));
      end
      check_eq("t2_ready_full", 64'(cmd_ready), 64'd0);
      wait_dones(5, 2000);
      for (int i = 0; i < 5; i++) begin
         if (done_tags.size() > i) begin
            check_eq($sformatf("t2_tag_%0d", i), 64'(done_tags[i]), 64'(i));
            check_eq($sformatf("t2_err_%0d", i), 64'(done_errs[i]), 64'd0);
         end
      end
      check_eq("t2_calc_cnt", 64'(calc_cnt - c0), 64'd5);
      check_eq("t2_last_size", 64'(launch_size), 64'd20);
      @(negedge clk);

      // 3. Illegal commands
      clear_log();
      c0 = calc_cnt;
      push_cmd(3'd5, 11'd8, 4'd7);
      push_cmd(3'd1, 11'd0, 4'd8);
      wait_dones(2, 200);
      if (done_tags.size() >= 2) begin
         check_eq("t3_tag0", 64'(done_tags[0]), 64'd7);
         check_eq("t3_err0", 64'(done_errs[0]), 64'd1);
         check_eq("t3_tag1", 64'(done_tags[1]), 64'd8);
         check_eq("t3_err1", 64'(done_errs[1]), 64'd1);
      end
      @(negedge clk);
      check_eq("t3_no_launch", 64'(calc_cnt - c0), 64'd0);
      check_eq("t3_busy", 64'(busy), 64'd0);

      // 4. Start timeout
      model_en = 1'b0;
      clear_log();
      c0 = calc_cnt;
      push_cmd(3'd2, 11'd16, 4'd5);
      wait_dones(1, 200);
      check_eq("t4_calc_cnt", 64'(calc_cnt - c0), 64'd1);
      if (done_tags.size() >= 1) begin
         check_eq("t4_tag", 64'(done_tags[0]), 64'd5);
         check_eq("t4_err", 64'(done_errs[0]), 64'd1);
         check_eq("t4_timeout_lat", 64'(done_cycs[0] - calc_cyc), 64'd9);
      end
      model_en = 1'b1;
      @(negedge clk);

      // 5. Reset mid-op
      clear_log();
      push_cmd(3'd1, 11'd8, 4'd9);
      push_cmd(3'd1, 11'd8, 4'd10);
      repeat (10) @(negedge clk);
      check_eq("t5_running", 64'(ctrl_state), 64'd1);
      rst_n = 1'b0;
      #1;
      check_eq("t5_rst_busy", 64'(busy), 64'd0);
      check_eq("t5_rst_ready", 64'(cmd_ready), 64'd0);
      check_eq("t5_rst_calc_init", 64'(calc_init), 64'd0);
      check_eq("t5_rst_done_tag", 64'(done_tag), 64'd0);
      check_eq("t5_rst_base_save", 64'(base_save), 64'd0);
      check_eq("t5_rst_size", 64'(matrix_size), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      c0 = calc_cnt;
      @(negedge clk);
      check_eq("t5_ready", 64'(cmd_ready), 64'd1);
      check_eq("t5_busy", 64'(busy), 64'd0);
      repeat (60) @(negedge clk);
      check_eq("t5_no_done", 64'(done_tags.size()), 64'd0);
      check_eq("t5_no_launch", 64'(calc_cnt - c0), 64'd0);

`ifdef MAT_SCHED_PERF_EN
      // 6. Perf counters
      check_eq("t6_ops_rst", 64'(perf_ops), 64'd0);
      check_eq("t6_busy_rst", 64'(perf_busy_cycles), 64'd0);
      clear_log();
      run_len = 40;
      push_cmd(3'd1, 11'd8, 4'd1);
      wait_dones(1, 300);
      run_len = 20;
      @(negedge clk);
      push_cmd(3'd2, 11'd8, 4'd2);
      wait_dones(2, 300);
      @(negedge clk);
      check_eq("t6_ops", 64'(perf_ops), 64'd2);
      check_eq("t6_busy_cycles", 64'(perf_busy_cycles), 64'd60);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
